// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, RV32I funct3 width codes
// and small helpers that classify an access by size and alignment.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } lsu_size_t;

  localparam logic [2:0] LSU_F3_B  = 3'b000;
  localparam logic [2:0] LSU_F3_H  = 3'b001;
  localparam logic [2:0] LSU_F3_W  = 3'b010;
  localparam logic [2:0] LSU_F3_BU = 3'b100;
  localparam logic [2:0] LSU_F3_HU = 3'b101;

  // Only the low two funct3 bits carry width; the reserved codes
  // 011, 110 and 111 fall through to word.
  function automatic lsu_size_t lsu_size(input logic [2:0] f3);
    if (f3[1:0] == LSU_F3_B[1:0]) return SIZE_B;
    else if (f3[1:0] == LSU_F3_H[1:0]) return SIZE_H;
    else return SIZE_W;
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (lsu_size(f3))
      SIZE_B:  return 1'b0;
      SIZE_H:  return lo[0];
      default: return (lo != 2'b00);
    endcase
  endfunction

  // Clears the low address bits that a halfword or word access cannot use.
  function automatic logic [31:0] lsu_align_addr(input logic [2:0] f3, input logic [31:0] a);
    case (lsu_size(f3))
      SIZE_B:  return a;
      SIZE_H:  return {a[31:1], 1'b0};
      default: return {a[31:2], 2'b00};
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: byte enables, store-data
// replication across lanes, and load lane extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed byte and halfword out of the returned word.
  always_comb begin
    lane_b = mem_rdata[7:0];
    case (addr_lo)
      2'd1:    lane_b = mem_rdata[15:8];
      2'd2:    lane_b = mem_rdata[23:16];
      2'd3:    lane_b = mem_rdata[31:24];
      default: lane_b = mem_rdata[7:0];
    endcase
    lane_h = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  // Enables, replicated store data and extended load data by access width.
  always_comb begin
    be          = 4'b1111;
    wdata_lanes = wdata;
    rdata_ext   = mem_rdata;
    case (lsu_size(funct3))
      SIZE_B: begin
        if (we) be = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = funct3[2] ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      end
      SIZE_H: begin
        if (we) be = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = funct3[2] ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      end
      default: begin
        be          = 4'b1111;
        wdata_lanes = wdata;
        rdata_ext   = mem_rdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one core request at a time, runs a single
// bus access with a timeout, and returns one completion pulse.
// Optional feature macro LSU_MISALIGN_TRAP_EN: when defined, misaligned
// halfword/word requests skip the bus and complete with misaligned=1;
// otherwise the offending low address bits are cleared and the access proceeds.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        bus_error,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CYCLE = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_t    state, state_next;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] count;
  logic [31:0]   rdata_q;
  logic          bus_error_q;
  logic          trap;
  logic [3:0]    be;
  logic [31:0]   wdata_lanes;
  logic [31:0]   rdata_ext;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned_q;
  assign trap       = lsu_misaligned(funct3, addr[1:0]);
  assign misaligned = misaligned_q;
`else
  assign trap       = 1'b0;
  assign misaligned = 1'b0;
`endif

  lsu_align u_align (
    .we          (we_q),
    .funct3      (f3_q),
    .addr_lo     (addr_q[1:0]),
    .wdata       (wdata_q),
    .mem_rdata   (mem_rdata),
    .be          (be),
    .wdata_lanes (wdata_lanes),
    .rdata_ext   (rdata_ext)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: a ready beat or the last permitted cycle ends the access.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = trap ? DONE : ACCESS;
      ACCESS:  if (mem_ready || (count == LAST_CYCLE)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, timeout counter and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= 32'b0;
      wdata_q     <= 32'b0;
      count       <= '0;
      rdata_q     <= 32'b0;
      bus_error_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_write;
            f3_q        <= funct3;
            addr_q      <= lsu_align_addr(funct3, addr);
            wdata_q     <= wdata;
            count       <= '0;
            rdata_q     <= 32'b0;
            bus_error_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misaligned_q <= trap;
`endif
          end
        end
        ACCESS: begin
          if (mem_ready) rdata_q <= we_q ? 32'b0 : rdata_ext;
          else if (count == LAST_CYCLE) bus_error_q <= 1'b1;
          else count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign mem_valid = (state == ACCESS);
  assign mem_we    = mem_valid & we_q;
  assign mem_be    = mem_valid ? be : 4'b0000;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_lanes;
  assign rdata     = rdata_q;
  assign bus_error = bus_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed corner cases followed by
// randomized transactions, all checked against a width/offset arithmetic model.
module tb_load_store_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        req_ready, rsp_valid, misaligned, bus_error;
  logic [31:0] rdata;
  logic        mem_valid, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rdata      (rdata),
    .misaligned (misaligned),
    .bus_error  (bus_error),
    .mem_valid  (mem_valid),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One full transaction: ready arrives in ACCESS cycle 'delay' (0-based);
  // a delay of TMO or more means ready never comes.
  task automatic applyStimulus(input string tag, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd,
                               input int delay, input logic [31:0] rd);
    int          n, off, cycles, exp_cycles;
    logic        exp_mis, exp_err, seen;
    logic [31:0] exp_be, exp_wd, exp_rd;
    longint      v;

    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    exp_mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    exp_mis = ((a % n) != 0);
`endif
    off = ((a % 4) / n) * n;
    exp_be = wr ? (((32'd1 << n) - 32'd1) << off) : 32'hF;
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % n) +: 8];
    v = longint'(rd);
    v = (v >> (8 * off)) & ((64'sd1 << (8 * n)) - 64'sd1);
    if (n < 4 && !f3[2] && v[8*n-1]) v = v - (64'sd1 << (8 * n));
    exp_rd = v[31:0];
    if (delay < TMO) begin
      exp_err = 1'b0;
      exp_cycles = delay + 1;
    end else begin
      exp_err = 1'b1;
      exp_cycles = TMO;
    end
    if (wr || exp_err) exp_rd = 32'b0;
    if (exp_mis) begin
      exp_rd = 32'b0;
      exp_err = 1'b0;
      exp_cycles = 0;
    end

    @(negedge clk);
    checkOutput({tag, ".req_ready_idle"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; funct3 = f3; addr = a; wdata = wd; mem_ready = 1'b0;
    cycles = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        req_valid = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end else if (mem_valid) begin
        checkOutput({tag, ".mem_addr"},  mem_addr, a & 32'hFFFF_FFFC);
        checkOutput({tag, ".mem_be"},    {28'b0, mem_be}, exp_be);
        checkOutput({tag, ".mem_we"},    {31'b0, mem_we}, {31'b0, wr});
        checkOutput({tag, ".mem_wdata"}, mem_wdata, exp_wd);
        checkOutput({tag, ".req_ready_busy"}, {31'b0, req_ready}, 32'd0);
        mem_ready = (cycles == delay);
        mem_rdata = (cycles == delay) ? rd : $urandom;
        cycles++;
      end
      // A competing request that the busy unit must ignore.
      req_write = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
    end
    req_valid = 1'b0;
    mem_ready = 1'b0;
    checkOutput({tag, ".rsp_seen"}, {31'b0, seen}, 32'd1);
    checkOutput({tag, ".mem_valid_cycles"}, cycles, exp_cycles);
    if (seen) begin
      checkOutput({tag, ".rdata"},      rdata, exp_rd);
      checkOutput({tag, ".bus_error"},  {31'b0, bus_error}, {31'b0, exp_err});
      checkOutput({tag, ".misaligned"}, {31'b0, misaligned}, {31'b0, exp_mis});
    end
    @(negedge clk);
    checkOutput({tag, ".rsp_one_cycle"}, {31'b0, rsp_valid}, 32'd0);
    checkOutput({tag, ".req_ready_after"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    logic       wr;
    logic [2:0] f3;
    bit         stray;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; funct3 = 3'b0;
    addr = 32'b0; wdata = 32'b0; mem_ready = 1'b0; mem_rdata = 32'b0;
    #2;
    checkOutput("reset.req_ready",  {31'b0, req_ready},  32'd1);
    checkOutput("reset.rsp_valid",  {31'b0, rsp_valid},  32'd0);
    checkOutput("reset.mem_valid",  {31'b0, mem_valid},  32'd0);
    checkOutput("reset.mem_we",     {31'b0, mem_we},     32'd0);
    checkOutput("reset.mem_be",     {28'b0, mem_be},     32'd0);
    checkOutput("reset.rdata",      rdata,               32'd0);
    checkOutput("reset.misaligned", {31'b0, misaligned}, 32'd0);
    checkOutput("reset.bus_error",  {31'b0, bus_error},  32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus("sb_0x103",  1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 0, 32'h0);
    applyStimulus("lb_0x102",  1'b0, 3'b000, 32'h0000_0102, 32'h0, 1, 32'h0080_0000);
    applyStimulus("lbu_0x102", 1'b0, 3'b100, 32'h0000_0102, 32'h0, 0, 32'h0080_0000);
    applyStimulus("lw_wait3",  1'b0, 3'b010, 32'h0000_0200, 32'h0, 3, 32'hCAFE_F00D);
    applyStimulus("lw_timeout", 1'b0, 3'b010, 32'h0000_0300, 32'h0, 99, 32'h1234_5678);
    applyStimulus("lw_ready_last", 1'b0, 3'b010, 32'h0000_0304, 32'h0, TMO - 1, 32'h8765_4321);
    applyStimulus("sw_timeout", 1'b1, 3'b010, 32'h0000_0308, 32'hDEAD_BEEF, 99, 32'h0);
    applyStimulus("lh_0x101",  1'b0, 3'b001, 32'h0000_0101, 32'h0, 0, 32'h1234_8001);
    applyStimulus("sh_0x101",  1'b1, 3'b001, 32'h0000_0101, 32'h0000_BEEF, 0, 32'h0);
    applyStimulus("lhu_0x102", 1'b0, 3'b101, 32'h0000_0102, 32'h0, 2, 32'h9876_0000);
    applyStimulus("lw_f3_111", 1'b0, 3'b111, 32'h0000_0107, 32'h0, 0, 32'hA5A5_0F0F);

    // Reset during the second ACCESS cycle abandons the access.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_0400; mem_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("rst_mid.access1", {31'b0, mem_valid}, 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_mid.mem_valid", {31'b0, mem_valid}, 32'd0);
    checkOutput("rst_mid.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_mid.req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rst_mid.mem_be",    {28'b0, mem_be},    32'd0);
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    stray = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rsp_valid || mem_valid) stray = 1'b1;
    end
    mem_ready = 1'b0;
    checkOutput("rst_mid.no_response", {31'b0, stray}, 32'd0);
    applyStimulus("after_reset_lw", 1'b0, 3'b010, 32'h0000_0404, 32'h0, 1, 32'h0BAD_CAFE);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom);
      f3 = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      applyStimulus("rand", wr, f3, $urandom, $urandom, $urandom_range(0, TMO + 1), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
